// File: rtl/bp_me_bedrock_data_serializer_pkg.sv
// rtl/bp_me_bedrock_data_serializer_pkg.sv - shared types and helpers for the BedRock data serializer
//
// Provides:
//   bp_bedrock_msg_size_e : encoded BedRock payload size (bytes = 1 << code)
//   bp_me_ser_state_e     : serializer FSM states
//   bedrock_size_bytes()  : decode a size code into a byte count
package bp_me_bedrock_data_serializer_pkg;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'b000,
    e_bedrock_msg_size_2   = 3'b001,
    e_bedrock_msg_size_4   = 3'b010,
    e_bedrock_msg_size_8   = 3'b011,
    e_bedrock_msg_size_16  = 3'b100,
    e_bedrock_msg_size_32  = 3'b101,
    e_bedrock_msg_size_64  = 3'b110,
    e_bedrock_msg_size_128 = 3'b111
  } bp_bedrock_msg_size_e;

  typedef enum logic [0:0] {
    e_ser_idle = 1'b0,
    e_ser_send = 1'b1
  } bp_me_ser_state_e;

  function automatic int unsigned bedrock_size_bytes(bp_bedrock_msg_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/bp_me_bedrock_data_serializer_size_to_flits.sv
// rtl/bp_me_bedrock_data_serializer_size_to_flits.sv - decode a BedRock size into a beat count
//
// Module bp_bedrock_size_to_flits (combinational).
// Ports:
//   size_i     : encoded payload size
//   has_data_i : 0 for header-only messages (always a single beat)
//   len_o      : number of beats minus one, saturated to max_flits_p-1
//   sub_flit_o : payload is narrower than one beat
module bp_bedrock_size_to_flits
  import bp_me_bedrock_data_serializer_pkg::*;
#(
  parameter int flit_width_p = 64,
  parameter int max_flits_p  = 8,
  parameter int width_p      = 3
) (
  input  bp_bedrock_msg_size_e size_i,
  input  logic                 has_data_i,
  output logic [width_p-1:0]   len_o,
  output logic                 sub_flit_o
);

  int unsigned bits;
  int unsigned flits;
  logic        illegal_size;

  always_comb begin
    bits         = bedrock_size_bytes(size_i) * 8;
    // Every legal size is at least one byte, so flits is never zero.
    flits        = (bits + flit_width_p - 1) / flit_width_p;
    illegal_size = has_data_i && (flits > max_flits_p);
    sub_flit_o   = has_data_i && (bits < flit_width_p);
    if (!has_data_i) begin
      len_o = '0;
    end else if (flits > max_flits_p) begin
      len_o = width_p'(max_flits_p - 1);
    end else begin
      len_o = width_p'(flits - 1);
    end
  end

  // A payload larger than the input bus cannot be represented; len saturates.
  always_comb begin
    assert (!illegal_size);
  end

endmodule

// File: rtl/bp_me_bedrock_data_serializer.sv
// rtl/bp_me_bedrock_data_serializer.sv - serialize one wide BedRock message into flit beats
//
// Optional feature macro: BP_ME_SERIALIZER_REPLICATE_EN
//   defined   : sub-flit payloads are replicated across the whole beat
//   undefined : sub-flit payloads sit at the LSBs, upper bits zero
// Ports:
//   clk_i, reset_n_i           : clock, asynchronous active-low reset
//   hdr_i, size_i, has_data_i,
//   data_i, v_i, ready_and_o   : input message and its valid/ready handshake
//   hdr_o, data_o, v_o,
//   ready_and_i                : output beat and its valid/ready handshake
//   first_o, last_o, cnt_o     : beat position markers
module bp_me_bedrock_data_serializer
  import bp_me_bedrock_data_serializer_pkg::*;
#(
  parameter int hdr_width_p  = 64,
  parameter int data_width_p = 512,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [hdr_width_p-1:0]  hdr_i,
  input  bp_bedrock_msg_size_e    size_i,
  input  logic                    has_data_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    v_i,
  output logic                    ready_and_o,
  output logic [hdr_width_p-1:0]  hdr_o,
  output logic [flit_width_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    ready_and_i,
  output logic                    first_o,
  output logic                    last_o,
  output logic [len_width_p-1:0]  cnt_o
);

  localparam int max_flits_lp = data_width_p / flit_width_p;

  bp_me_ser_state_e state_r, state_n;

  logic [len_width_p-1:0]                      cnt_r;
  logic [len_width_p-1:0]                      len_r;
  logic [len_width_p-1:0]                      len_n;
  logic [hdr_width_p-1:0]                      hdr_r;
  logic [max_flits_lp-1:0][flit_width_p-1:0]   data_r;
  logic [max_flits_lp-1:0][flit_width_p-1:0]   data_n;
  logic                                        sub_flit;
  logic                                        capture;
  logic                                        beat_done;
  logic                                        burst_done;

  bp_bedrock_size_to_flits #(
    .flit_width_p (flit_width_p),
    .max_flits_p  (max_flits_lp),
    .width_p      (len_width_p)
  ) size_decode (
    .size_i     (size_i),
    .has_data_i (has_data_i),
    .len_o      (len_n),
    .sub_flit_o (sub_flit)
  );

  // Sub-flit packing is resolved at capture time so the send path is a plain
  // beat select regardless of size.
  int unsigned              payload_bits;
  logic [flit_width_p-1:0]  low_flit;
  logic [flit_width_p-1:0]  packed_flit;
`ifdef BP_ME_SERIALIZER_REPLICATE_EN
  localparam int idx_width_lp = $clog2(flit_width_p);
  logic [idx_width_lp-1:0]  rep_idx;
`endif

  always_comb begin
    payload_bits = bedrock_size_bytes(size_i) * 8;
    low_flit     = data_i[flit_width_p-1:0];
    packed_flit  = '0;
`ifdef BP_ME_SERIALIZER_REPLICATE_EN
    rep_idx      = '0;
`endif
    for (int i = 0; i < flit_width_p; i++) begin
`ifdef BP_ME_SERIALIZER_REPLICATE_EN
      // payload_bits is a power of two, so masking wraps the bit index.
      rep_idx        = idx_width_lp'(i & (payload_bits - 1));
      packed_flit[i] = low_flit[rep_idx];
`else
      if (i < payload_bits) begin
        packed_flit[i] = low_flit[i];
      end
`endif
    end

    data_n = '0;
    if (has_data_i) begin
      if (sub_flit) begin
        data_n[0] = packed_flit;
      end else begin
        data_n = data_i;
      end
    end
  end

  always_comb begin
    state_n = state_r;
    v_o     = 1'b0;
    first_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    case (state_r)
      e_ser_idle: begin
        if (v_i) begin
          state_n = e_ser_send;
        end
      end
      e_ser_send: begin
        v_o     = 1'b1;
        first_o = (cnt_r == '0);
        last_o  = (cnt_r == len_r);
        data_o  = data_r[cnt_r];
        // A new message offered on the last beat keeps us in SEND.
        if (ready_and_i && last_o && !v_i) begin
          state_n = e_ser_idle;
        end
      end
      default: state_n = e_ser_idle;
    endcase
  end

  // Combinational from ready_and_i on purpose: it lets the next message be
  // accepted on the final beat of the current one with no bubble.
  assign ready_and_o = (state_r == e_ser_idle) | (last_o & ready_and_i);
  assign capture     = v_i & ready_and_o;
  assign beat_done   = v_o & ready_and_i;
  assign burst_done  = beat_done & last_o;

  assign hdr_o = hdr_r;
  assign cnt_o = cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ser_idle;
    end else begin
      state_r <= state_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r  <= '0;
      len_r  <= '0;
      hdr_r  <= '0;
      data_r <= '0;
    end else if (capture) begin
      cnt_r  <= '0;
      len_r  <= len_n;
      hdr_r  <= hdr_i;
      data_r <= data_n;
    end else if (beat_done) begin
      cnt_r  <= burst_done ? '0 : cnt_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_me_bedrock_data_serializer.sv
// tb/tb_bp_me_bedrock_data_serializer.sv - scoreboard bench for the BedRock data serializer
module tb_bp_me_bedrock_data_serializer;
  import bp_me_bedrock_data_serializer_pkg::*;

  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] data;
    logic        first;
    logic        last;
    logic [2:0]  cnt;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [63:0]          hdr_i = '0;
  bp_bedrock_msg_size_e size_i = e_bedrock_msg_size_1;
  logic                 has_data_i = 1'b0;
  logic [511:0]         data_i = '0;
  logic                 v_i = 1'b0;
  logic                 ready_and_o;
  logic [63:0]          hdr_o;
  logic [63:0]          data_o;
  logic                 v_o;
  logic                 ready_and_i = 1'b1;
  logic                 first_o;
  logic                 last_o;
  logic [2:0]           cnt_o;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  bp_me_bedrock_data_serializer dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .hdr_i       (hdr_i),
    .size_i      (size_i),
    .has_data_i  (has_data_i),
    .data_i      (data_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .hdr_o       (hdr_o),
    .data_o      (data_o),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .first_o     (first_o),
    .last_o      (last_o),
    .cnt_o       (cnt_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Payload whose byte i equals base+i.
  function automatic logic [511:0] gen_data(input logic [7:0] base);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(base + i);
    return d;
  endfunction

  // Beat k of gen_data(base): bytes 8k..8k+7.
  function automatic logic [63:0] beat_of(input logic [7:0] base, input int k);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(base + 8*k + j);
    return r;
  endfunction

  task automatic push(input logic [63:0] h, input logic [63:0] d, input logic f,
                      input logic l, input logic [2:0] c);
    beat_t b;
    b.hdr = h; b.data = d; b.first = f; b.last = l; b.cnt = c;
    exp_q.push_back(b);
  endtask

  task automatic push_burst(input logic [63:0] h, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) push(h, beat_of(base, k), k == 0, k == n - 1, 3'(k));
  endtask

  // Offer a message; returns one tick after the accepting edge.
  task automatic send_msg(input logic [63:0] h, input bp_bedrock_msg_size_e s,
                          input logic hd, input logic [511:0] d, output logic was_last);
    int n;
    n = 0;
    @(posedge clk); #1;
    hdr_i = h; size_i = s; has_data_i = hd; data_i = d; v_i = 1'b1;
    #1;
    while (!ready_and_o && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!ready_and_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 expected=1");
    end
    was_last = v_o & last_o;
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  // Apply a per-cycle ready pattern until the scoreboard drains; returns cycles.
  task automatic run_until_empty(input logic [15:0] pat, output int n);
    n = 0;
    while (n < 200) begin
      ready_and_i = (n < 16) ? pat[n[3:0]] : 1'b1;
      @(posedge clk); #1;
      n++;
      if (exp_q.size() == 0) break;
    end
    ready_and_i = 1'b1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
    end
  endtask

  // Monitor: every presented beat is compared with the scoreboard head, popped on handshake.
  initial begin
    beat_t act;
    forever begin
      @(negedge clk);
      if (rst_n && v_o) begin
        act = {hdr_o, data_o, first_o, last_o, cnt_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", act);
        end else begin
          if (act !== exp_q[0]) begin
            errors++;
            $display("FAIL beat actual=%h expected=%h", act, exp_q[0]);
          end
          if (ready_and_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         wl;
    int           n;
    logic [511:0] d;
    logic [63:0]  exp_sub;

    // Reset state
    #3;
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_ready", 64'(ready_and_o), 64'd1);
    check("rst_first", 64'(first_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_hdr", hdr_o, 64'd0);
    check("rst_data", data_o, 64'd0);
    #14 rst_n = 1'b1;

    // size_64 full-rate burst
    push_burst(64'h1111_2222_3333_4444, 8'h00, 8);
    send_msg(64'h1111_2222_3333_4444, e_bedrock_msg_size_64, 1'b1, gen_data(8'h00), wl);
    check("s64_accept_idle", 64'(wl), 64'd0);
    run_until_empty(16'hFFFF, n);
    check("s64_cycles", 64'(n), 64'd8);
    check("s64_idle_v", 64'(v_o), 64'd0);
    check("s64_idle_ready", 64'(ready_and_o), 64'd1);

    // size_4 sub-flit beat, garbage above the payload
    d = gen_data(8'h00);
    d[63:0] = 64'hCAFEF00D_DEADBEEF;
`ifdef BP_ME_SERIALIZER_REPLICATE_EN
    exp_sub = 64'hDEADBEEF_DEADBEEF;
`else
    exp_sub = 64'h00000000_DEADBEEF;
`endif
    push(64'hA5A5_0000_0000_0004, exp_sub, 1'b1, 1'b1, 3'd0);
    send_msg(64'hA5A5_0000_0000_0004, e_bedrock_msg_size_4, 1'b1, d, wl);
    run_until_empty(16'hFFFF, n);
    check("s4_cycles", 64'(n), 64'd1);

    // size_32 with ready 1,0,0,1,1,1
    push_burst(64'h0000_0000_0000_0032, 8'h40, 4);
    send_msg(64'h0000_0000_0000_0032, e_bedrock_msg_size_32, 1'b1, gen_data(8'h40), wl);
    run_until_empty(16'hFFF9, n);
    check("s32_bp_cycles", 64'(n), 64'd6);

    // Two size_16 messages back to back
    push_burst(64'hAAAA_0000_0000_0016, 8'h80, 2);
    push_burst(64'hBBBB_0000_0000_0016, 8'hC0, 2);
    send_msg(64'hAAAA_0000_0000_0016, e_bedrock_msg_size_16, 1'b1, gen_data(8'h80), wl);
    send_msg(64'hBBBB_0000_0000_0016, e_bedrock_msg_size_16, 1'b1, gen_data(8'hC0), wl);
    check("b2b_accept_on_last", 64'(wl), 64'd1);
    check("b2b_queue_after_accept", 64'(exp_q.size()), 64'd2);
    run_until_empty(16'hFFFF, n);
    check("b2b_cycles", 64'(n), 64'd2);

    // Header-only message
    push(64'hDEAD_0000_0000_BEEF, 64'd0, 1'b1, 1'b1, 3'd0);
    send_msg(64'hDEAD_0000_0000_BEEF, e_bedrock_msg_size_64, 1'b0, gen_data(8'h55), wl);
    run_until_empty(16'hFFFF, n);
    check("nodata_cycles", 64'(n), 64'd1);

    // Asynchronous reset at beat 3
    push_burst(64'h5555_6666_7777_8888, 8'h20, 8);
    send_msg(64'h5555_6666_7777_8888, e_bedrock_msg_size_64, 1'b1, gen_data(8'h20), wl);
    repeat (3) @(posedge clk);
    #2;
    check("mid_cnt", 64'(cnt_o), 64'd3);
    check("mid_queue", 64'(exp_q.size()), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    check("arst_v_o", 64'(v_o), 64'd0);
    check("arst_ready", 64'(ready_and_o), 64'd1);
    check("arst_cnt", 64'(cnt_o), 64'd0);
    exp_q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_v_o", 64'(v_o), 64'd0);
    push_burst(64'h0F0F_0000_0000_0016, 8'h10, 2);
    send_msg(64'h0F0F_0000_0000_0016, e_bedrock_msg_size_16, 1'b1, gen_data(8'h10), wl);
    run_until_empty(16'hFFFF, n);
    check("post_rst_cycles", 64'(n), 64'd2);

    repeat (3) @(posedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
